bpu: RTL and testbench
======================

BPU -- requirements
Module: bpu

Interface
REQ-001 The bpu SHALL expose the following parameters (name, default, meaning):
- BHT_INDEX_W, 4: counter-table index width.
- BHT_DEPTH, 16: counter entries, equal to 2^BHT_INDEX_W.
REQ-002 The bpu SHALL provide the following ports (name, direction, width, meaning):
- clk, in, 1: single clock; all state changes on its rising edge.
- rstn, in, 1: reset; asynchronous, active-low.
- if_valid_i, in, 1: fetched instruction valid.
- if_instaddr_i, in, 32: address of the fetched instruction.
- if_inst_i, in, 32: fetched instruction word.
- ex_br_valid_i, in, 1: a conditional branch resolved in EX this cycle.
- ex_instaddr_i, in, 32: address of the resolved branch.
- ex_jump_en_i, in, 1: actual branch outcome (1 = taken).
- ex_prd_taken_i, in, 1: prediction that was carried with that branch.
- prd_jump_en_o, out, 1: predicted redirect to the PC.
- prd_jump_base_o, out, 32: redirect base.
- prd_jump_ofset_o, out, 32: redirect offset; target = base + offset.
- prd_taken_o, out, 1: prediction flag, pipelined downstream to EX.
- mispred_cnt_o, out, 32: saturating misprediction count.

Function
REQ-003 Lookup SHALL be combinational with zero latency: outputs depend on the current if_* inputs and the registered table only.
REQ-004 Decode (opcode = if_inst_i[6:0]):
- JAL (1101111): always predict taken.
- B-type (1100011): predict taken when counter[idx] >= 2.
- Any other opcode: predict not taken.
REQ-005 Index SHALL be idx = if_instaddr_i[BHT_INDEX_W+1:2] for lookup and ex_instaddr_i[BHT_INDEX_W+1:2] for update.
REQ-006 prd_jump_en_o and prd_taken_o SHALL equal if_valid_i AND the predict-taken decision.
REQ-007 prd_jump_base_o SHALL equal if_instaddr_i whenever prd_jump_en_o=1, and 0 otherwise.
REQ-008 prd_jump_ofset_o SHALL be the sign-extended immediate whenever prd_jump_en_o=1, and 4 otherwise.
- B-type immediate: {inst[31],inst[7],inst[30:25],inst[11:8],0}.
- JAL immediate: {inst[31],inst[19:12],inst[20],inst[30:21],0}.
REQ-009 Counters SHALL be 2 bits wide with encoding 0 strong-NT, 1 weak-NT, 2 weak-T, 3 strong-T.
REQ-010 On a rising edge with ex_br_valid_i=1:
- ex_jump_en_i=1: counter[idx] increments, saturating at 3.
- ex_jump_en_i=0: counter[idx] decrements, saturating at 0.
REQ-011 Only one entry SHALL be written per cycle; entries not written SHALL hold their value.
REQ-012 When lookup and update hit the same index in the same cycle, the lookup SHALL see the pre-update value (no bypass); the new value is visible the next cycle.
REQ-013 On a rising edge with ex_br_valid_i=1 and ex_jump_en_i != ex_prd_taken_i, mispred_cnt_o SHALL increment by 1, saturating at 32'hFFFF_FFFF.
REQ-014 The bpu SHALL NOT observe pipeline hold; the table updates on every valid resolution regardless of stalls.
REQ-015 ex_* inputs SHALL be ignored while ex_br_valid_i=0.

Reset
REQ-016 While rstn=0, asynchronously:
- every counter SHALL be 1 (weak-NT);
- mispred_cnt_o SHALL be 0.
REQ-017 Reset asserted mid-update SHALL discard that update; the first edge after rstn rises SHALL process inputs normally.
REQ-018 During reset, the combinational outputs SHALL reflect the reset table (B-type predicted not taken).

Structure
REQ-019 The shared defines file SHALL hold:
- opcodes INST_TYPE_B and INST_JAL;
- counter encodings and the reset counter value;
- JumpEnable/JumpDisable, RstEnable and InstAddrBus.
REQ-020 The counter table SHALL be a sub-module bpu_bht (one read port, one saturating-update port); decode and immediate generation stay in bpu.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Reset, then present B-type at 0x100 (imm +16) -> prd_jump_en_o=0, ofset=4.
- Two taken resolutions at 0x100, then re-fetch -> prd_jump_en_o=1, base=0x100, ofset=16.
- JAL at 0x200 with imm -8, fresh table -> prd_jump_en_o=1, ofset=0xFFFF_FFF8.
- Four not-taken resolutions at idx 0 from state 3 -> counter reaches 0 and stays 0; extra taken -> 1.
- Same-cycle lookup and update at the same index -> lookup uses old value; next cycle uses new value.
- Five mismatched resolutions, with rstn pulsed low after the third -> mispred_cnt_o reads 3, then 0, then 2.

Source files
------------

// File: rtl/bpu_pkg.sv
// Shared definitions for the branch prediction unit: opcodes, counter
// encodings and common bus/level constants.
package bpu_pkg;

  localparam int InstAddrBus = 32;

  localparam logic JumpEnable  = 1'b1;
  localparam logic JumpDisable = 1'b0;
  localparam logic RstEnable   = 1'b0;

  localparam logic [6:0] INST_TYPE_B = 7'b1100011;
  localparam logic [6:0] INST_JAL    = 7'b1101111;

  // 2-bit saturating counter states; bit 1 set means "predict taken"
  typedef enum logic [1:0] {
    CNT_SNT = 2'd0,
    CNT_WNT = 2'd1,
    CNT_WT  = 2'd2,
    CNT_ST  = 2'd3
  } bht_cnt_e;

  localparam bht_cnt_e CNT_RST = CNT_WNT;

endpackage

// File: rtl/bpu_bht.sv
// Branch history table: DEPTH 2-bit saturating counters, one combinational
// read port and one saturating-update write port.
module bpu_bht
  import bpu_pkg::*;
#(
  parameter int INDEX_W = 4,
  parameter int DEPTH   = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [INDEX_W-1:0] rd_idx_i,
  output bht_cnt_e           rd_cnt_o,
  input  logic               wr_en_i,
  input  logic [INDEX_W-1:0] wr_idx_i,
  input  logic               wr_taken_i
);

  bht_cnt_e cnt_q [DEPTH];
  bht_cnt_e wr_cnt_d;

  // Move one step toward the observed outcome, clamping at the strong states
  function automatic bht_cnt_e sat_update(bht_cnt_e cnt, logic taken);
    bht_cnt_e res;
    res = cnt;
    if (taken) begin
      if (cnt != CNT_ST) res = bht_cnt_e'(cnt + 2'd1);
    end else begin
      if (cnt != CNT_SNT) res = bht_cnt_e'(cnt - 2'd1);
    end
    return res;
  endfunction

  // Lookup reads registered state only, so a same-cycle update is not bypassed
  assign rd_cnt_o = cnt_q[rd_idx_i];

  // Next value for the single entry being updated this cycle
  always_comb begin
    wr_cnt_d = sat_update(cnt_q[wr_idx_i], wr_taken_i);
  end

  // Counter table: async reset to weak-not-taken, one entry written per edge
  always_ff @(posedge clk or negedge rstn) begin
    if (rstn == RstEnable) begin
      for (int i = 0; i < DEPTH; i++) cnt_q[i] <= CNT_RST;
    end else if (wr_en_i) begin
      cnt_q[wr_idx_i] <= wr_cnt_d;
    end
  end

endmodule

// File: rtl/bpu.sv
// Branch prediction unit: zero-latency lookup with JAL/B-type decode and
// immediate generation, BHT training from EX, and a misprediction counter.
module bpu
  import bpu_pkg::*;
#(
  parameter int BHT_INDEX_W = 4,
  parameter int BHT_DEPTH   = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   if_valid_i,
  input  logic [InstAddrBus-1:0] if_instaddr_i,
  input  logic [31:0]            if_inst_i,
  input  logic                   ex_br_valid_i,
  input  logic [InstAddrBus-1:0] ex_instaddr_i,
  input  logic                   ex_jump_en_i,
  input  logic                   ex_prd_taken_i,
  output logic                   prd_jump_en_o,
  output logic [InstAddrBus-1:0] prd_jump_base_o,
  output logic [31:0]            prd_jump_ofset_o,
  output logic                   prd_taken_o,
  output logic [31:0]            mispred_cnt_o
);

  logic [6:0]             opcode;
  logic                   is_b;
  logic                   is_jal;
  logic                   pred_taken;
  logic                   jump_en;
  logic signed [31:0]     imm_b;
  logic signed [31:0]     imm_j;
  bht_cnt_e               rd_cnt;
  logic [BHT_INDEX_W-1:0] rd_idx;
  logic [BHT_INDEX_W-1:0] wr_idx;
  logic [31:0]            mispred_q;
  logic [31:0]            mispred_d;
  logic                   unused_addr_bits;

  // Word-aligned address bits select the counter; the rest are don't-care
  assign rd_idx = if_instaddr_i[BHT_INDEX_W+1:2];
  assign wr_idx = ex_instaddr_i[BHT_INDEX_W+1:2];
  assign unused_addr_bits = ^{ex_instaddr_i[InstAddrBus-1:BHT_INDEX_W+2],
                              ex_instaddr_i[1:0]};

  bpu_bht #(
    .INDEX_W (BHT_INDEX_W),
    .DEPTH   (BHT_DEPTH)
  ) u_bht (
    .clk        (clk),
    .rstn       (rstn),
    .rd_idx_i   (rd_idx),
    .rd_cnt_o   (rd_cnt),
    .wr_en_i    (ex_br_valid_i),
    .wr_idx_i   (wr_idx),
    .wr_taken_i (ex_jump_en_i)
  );

  // Decode, sign-extended immediates and redirect outputs
  always_comb begin
    opcode     = if_inst_i[6:0];
    is_b       = (opcode == INST_TYPE_B);
    is_jal     = (opcode == INST_JAL);
    imm_b      = {{19{if_inst_i[31]}}, if_inst_i[31], if_inst_i[7],
                  if_inst_i[30:25], if_inst_i[11:8], 1'b0};
    imm_j      = {{11{if_inst_i[31]}}, if_inst_i[31], if_inst_i[19:12],
                  if_inst_i[20], if_inst_i[30:21], 1'b0};
    pred_taken = is_jal | (is_b & rd_cnt[1]);
    jump_en    = if_valid_i ? pred_taken : JumpDisable;

    prd_jump_en_o    = jump_en;
    prd_taken_o      = jump_en;
    prd_jump_base_o  = '0;
    prd_jump_ofset_o = 32'd4;
    if (jump_en == JumpEnable) begin
      prd_jump_base_o  = if_instaddr_i;
      prd_jump_ofset_o = is_jal ? imm_j : imm_b;
    end
  end

  // Misprediction count, saturating at all-ones
  always_comb begin
    mispred_d = mispred_q;
    if (ex_br_valid_i && (ex_jump_en_i != ex_prd_taken_i) && (mispred_q != '1))
      mispred_d = mispred_q + 32'd1;
  end

  // Misprediction count register
  always_ff @(posedge clk or negedge rstn) begin
    if (rstn == RstEnable) mispred_q <= '0;
    else                   mispred_q <= mispred_d;
  end

  assign mispred_cnt_o = mispred_q;

endmodule

// File: tb/tb_bpu.sv
// Self-checking bench for bpu: directed scenarios plus randomized traffic
// compared against a behavioural table/counter model.
module tb_bpu;

  logic        clk  = 1'b0;
  logic        rstn = 1'b1;
  logic        if_valid_i = 1'b0;
  logic [31:0] if_instaddr_i = '0;
  logic [31:0] if_inst_i = '0;
  logic        ex_br_valid_i = 1'b0;
  logic [31:0] ex_instaddr_i = '0;
  logic        ex_jump_en_i = 1'b0;
  logic        ex_prd_taken_i = 1'b0;
  logic        prd_jump_en_o;
  logic [31:0] prd_jump_base_o;
  logic [31:0] prd_jump_ofset_o;
  logic        prd_taken_o;
  logic [31:0] mispred_cnt_o;

  int          n_vec = 0;
  int          n_err = 0;

  // behavioural model state
  int          cnt_m [16];
  logic [31:0] mis_m;

  bpu #(.BHT_INDEX_W(4), .BHT_DEPTH(16)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .if_valid_i       (if_valid_i),
    .if_instaddr_i    (if_instaddr_i),
    .if_inst_i        (if_inst_i),
    .ex_br_valid_i    (ex_br_valid_i),
    .ex_instaddr_i    (ex_instaddr_i),
    .ex_jump_en_i     (ex_jump_en_i),
    .ex_prd_taken_i   (ex_prd_taken_i),
    .prd_jump_en_o    (prd_jump_en_o),
    .prd_jump_base_o  (prd_jump_base_o),
    .prd_jump_ofset_o (prd_jump_ofset_o),
    .prd_taken_o      (prd_taken_o),
    .mispred_cnt_o    (mispred_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Instruction encoders built from a byte offset (inverse of the decode rules)
  function automatic logic [31:0] enc_b(input int imm);
    logic [31:0] v;
    v = imm;
    return {v[12], v[10:5], 5'd1, 5'd2, 3'd0, v[4:1], v[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_jal(input int imm);
    logic [31:0] v;
    v = imm;
    return {v[20], v[10:1], v[11], v[19:12], 5'd1, 7'b1101111};
  endfunction

  // Immediate values as plain signed arithmetic on the instruction fields
  function automatic int imm_b_of(input logic [31:0] w);
    return (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32
           + int'(w[11:8]) * 2;
  endfunction

  function automatic int imm_j_of(input logic [31:0] w);
    return (w[31] ? -(1 << 20) : 0) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048
           + int'(w[30:21]) * 2;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) cnt_m[i] = 1;
    mis_m = '0;
  endtask

  task automatic model_edge();
    int idx;
    if (rstn && ex_br_valid_i) begin
      idx = int'(ex_instaddr_i[5:2]);
      if (ex_jump_en_i) cnt_m[idx] = (cnt_m[idx] < 3) ? cnt_m[idx] + 1 : 3;
      else              cnt_m[idx] = (cnt_m[idx] > 0) ? cnt_m[idx] - 1 : 0;
      if ((ex_jump_en_i != ex_prd_taken_i) && (mis_m != 32'hFFFF_FFFF)) mis_m++;
    end
  endtask

  task automatic check_outputs();
    logic        taken;
    logic [31:0] e_base, e_ofs;
    taken  = 1'b0;
    e_base = 32'd0;
    e_ofs  = 32'd4;
    if (if_valid_i) begin
      if (if_inst_i[6:0] == 7'b1101111) taken = 1'b1;
      else if (if_inst_i[6:0] == 7'b1100011) taken = (cnt_m[int'(if_instaddr_i[5:2])] >= 2);
    end
    if (taken) begin
      e_base = if_instaddr_i;
      e_ofs  = (if_inst_i[6:0] == 7'b1101111) ? imm_j_of(if_inst_i) : imm_b_of(if_inst_i);
    end
    chk("jump_en", {31'd0, prd_jump_en_o}, {31'd0, taken});
    chk("taken",   {31'd0, prd_taken_o},   {31'd0, taken});
    chk("base",    prd_jump_base_o,  e_base);
    chk("ofset",   prd_jump_ofset_o, e_ofs);
    chk("mispred", mispred_cnt_o,    mis_m);
  endtask

  // Called just after a falling edge with inputs set: check, clock, advance model
  task automatic tick();
    #1 check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    rstn = 1'b0;
    model_reset();
    #1 check_outputs();
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic set_if(input logic v, input logic [31:0] a, input logic [31:0] w);
    if_valid_i = v; if_instaddr_i = a; if_inst_i = w;
  endtask

  task automatic set_ex(input logic v, input logic [31:0] a, input logic j, input logic p);
    ex_br_valid_i = v; ex_instaddr_i = a; ex_jump_en_i = j; ex_prd_taken_i = p;
  endtask

  initial begin
    model_reset();
    // reset, B-type +16 at 0x100 seen through the reset table
    #2 rstn = 1'b0;
    set_if(1'b1, 32'h100, enc_b(16));
    #1 chk("rst_en", {31'd0, prd_jump_en_o}, 32'd0);
    chk("rst_mis", mispred_cnt_o, 32'd0);
    check_outputs();
    @(negedge clk);
    rstn = 1'b1;
    #1 chk("b_cold_ofs", prd_jump_ofset_o, 32'd4);
    tick();

    // two taken resolutions at 0x100 then re-fetch
    set_if(1'b0, 32'h0, 32'h0);
    set_ex(1'b1, 32'h100, 1'b1, 1'b0);
    tick();
    tick();
    set_ex(1'b0, 32'h0, 1'b0, 1'b0);
    set_if(1'b1, 32'h100, enc_b(16));
    #1 chk("b_hot_en", {31'd0, prd_jump_en_o}, 32'd1);
    chk("b_hot_base", prd_jump_base_o, 32'h100);
    chk("b_hot_ofs", prd_jump_ofset_o, 32'd16);
    tick();

    // JAL -8 at 0x200 on a fresh table
    pulse_reset();
    set_if(1'b1, 32'h200, enc_jal(-8));
    #1 chk("jal_en", {31'd0, prd_jump_en_o}, 32'd1);
    chk("jal_base", prd_jump_base_o, 32'h200);
    chk("jal_ofs", prd_jump_ofset_o, 32'hFFFF_FFF8);
    tick();

    // idx 0: drive to 3, then four not-taken down to 0 and hold
    set_if(1'b1, 32'h0, enc_b(-64));
    set_ex(1'b1, 32'h0, 1'b1, 1'b1);
    repeat (2) tick();
    set_ex(1'b1, 32'h40, 1'b0, 1'b0);
    repeat (4) tick();
    set_ex(1'b0, 32'h0, 1'b0, 1'b0);
    #1 chk("sat0_en", {31'd0, prd_jump_en_o}, 32'd0);
    tick();
    set_ex(1'b1, 32'h0, 1'b1, 1'b0);
    tick();
    set_ex(1'b0, 32'h0, 1'b0, 1'b0);
    #1 chk("from0_en", {31'd0, prd_jump_en_o}, 32'd0);
    tick();
    set_ex(1'b1, 32'h0, 1'b1, 1'b0);
    tick();
    set_ex(1'b0, 32'h0, 1'b0, 1'b0);
    #1 chk("from1_en", {31'd0, prd_jump_en_o}, 32'd1);
    tick();

    // same-cycle lookup/update at idx 0 with counter at 1
    set_ex(1'b1, 32'h0, 1'b0, 1'b1);
    tick();
    set_ex(1'b1, 32'h0, 1'b1, 1'b0);
    #1 chk("same_old", {31'd0, prd_jump_en_o}, 32'd0);
    tick();
    set_ex(1'b0, 32'h0, 1'b0, 1'b0);
    #1 chk("same_new", {31'd0, prd_jump_en_o}, 32'd1);
    tick();

    // five mismatches with reset after the third (the pending one is dropped)
    pulse_reset();
    set_if(1'b0, 32'h0, 32'h0);
    set_ex(1'b1, 32'h44, 1'b1, 1'b0);
    repeat (3) tick();
    #1 chk("mis_3", mispred_cnt_o, 32'd3);
    rstn = 1'b0;
    model_reset();
    #1 chk("mis_rst", mispred_cnt_o, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) tick();
    set_ex(1'b0, 32'h0, 1'b0, 1'b0);
    #1 chk("mis_2", mispred_cnt_o, 32'd2);
    tick();

    // randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      logic [31:0] w, a, ea;
      int kind;
      kind = $urandom_range(0, 3);
      w = $urandom;
      if (kind <= 1) w[6:0] = 7'b1100011;
      else if (kind == 2) w[6:0] = 7'b1101111;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[31:6] = '0;
      ea = $urandom;
      if ($urandom_range(0, 3) != 0) ea[31:6] = '0;
      if ($urandom_range(0, 3) == 0) ea = a;
      set_if($urandom_range(0, 4) != 0, a, w);
      set_ex($urandom_range(0, 1) == 1, ea, $urandom_range(0, 1) == 1,
             $urandom_range(0, 1) == 1);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
